// File: rtl/pipe_ctrl.sv
// pipe_ctrl: arbitrates the single memory-controller port between instruction
// fetch and the MEM stage, builds the per-stage stall vector, and drives the
// IF/ID and ID/EX discard controls. A taken branch seen while a fetch is in
// flight is remembered so that the stale fetch data is dropped on completion.
module pipe_ctrl (
   input  logic       clk,
   input  logic       rst,              // active-low, asynchronous
   input  logic       if_req,
   input  logic       mem_req,
   input  logic       mc_done,
   input  logic       id_load_use,
   input  logic       ex_branch_taken,
   output logic       if_gnt,
   output logic       mem_gnt,
   output logic       mc_start,
   output logic       if_drop,
   output logic [5:0] stall,
   output logic       IFID_discard_o,
   output logic       IDEX_discard_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } state_t;

   // stall encodings, bit0 = pc ... bit5 = WB
   localparam logic [5:0] STALL_MEM = 6'b011111;
   localparam logic [5:0] STALL_LU  = 6'b000111;
   localparam logic [5:0] STALL_IF  = 6'b000011;

   state_t state_q, state_d;
   logic   br_pending_q, br_pending_d;
   logic   mc_start_q, mc_start_d;

   logic in_if, in_mem;
   logic if_done, mem_done;
   logic mem_wait, if_wait;

   assign in_if    = (state_q == IF_BUSY);
   assign in_mem   = (state_q == MEM_BUSY);
   assign if_done  = in_if & mc_done;
   assign mem_done = in_mem & mc_done;

   // A stage stops waiting in the very cycle its transaction completes.
   assign mem_wait = mem_req & ~mem_done;
   assign if_wait  = if_req & ~if_done;

   // Next-state: MEM wins in IDLE (older instruction); every grant returns to
   // IDLE for at least one cycle, so mc_start is simply "entering BUSY".
   always_comb begin
      state_d    = state_q;
      mc_start_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_req) begin
               state_d    = MEM_BUSY;
               mc_start_d = 1'b1;
            end else if (if_req) begin
               state_d    = IF_BUSY;
               mc_start_d = 1'b1;
            end
         end
         IF_BUSY, MEM_BUSY: begin
            if (mc_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Branch-pending flag: a redirect accepted mid-fetch marks the in-flight
   // fetch as stale; cleared when that fetch completes. A redirect in the
   // completion cycle itself is handled directly by if_drop.
   always_comb begin
      br_pending_d = br_pending_q;
      if (if_done)
         br_pending_d = 1'b0;
      else if (~mem_wait & ex_branch_taken & in_if)
         br_pending_d = 1'b1;
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         br_pending_q <= 1'b0;
         mc_start_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         br_pending_q <= br_pending_d;
         mc_start_q   <= mc_start_d;
      end
   end

   // Stall vector and discards; a MEM stall freezes EX, so a branch seen
   // under it is ignored until EX re-presents it.
   always_comb begin
      stall = 6'b000000;
      if (mem_wait)
         stall = STALL_MEM;
      else if (id_load_use)
         stall = STALL_LU;
      else if (if_wait)
         stall = STALL_IF;
   end

   assign IDEX_discard_o = ~mem_wait & (id_load_use | ex_branch_taken);
   assign IFID_discard_o = ~mem_wait & ex_branch_taken;

   assign if_gnt   = in_if;
   assign mem_gnt  = in_mem;
   assign mc_start = mc_start_q;
   assign if_drop  = if_done & (br_pending_q | ex_branch_taken);

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven check of pipe_ctrl. Each row drives one cycle of
// inputs; the expected output word is queued at drive time and compared on the
// following falling edge. Reset corner cases are hand-written sequences.
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       if_req = 1'b0, mem_req = 1'b0, mc_done = 1'b0;
   logic       id_load_use = 1'b0, ex_branch_taken = 1'b0;
   logic       if_gnt, mem_gnt, mc_start, if_drop;
   logic [5:0] stall;
   logic       IFID_discard_o, IDEX_discard_o;

   int n_checks = 0;
   int n_fail   = 0;

   // output word: {if_gnt, mem_gnt, mc_start, if_drop, stall[5:0], ifid, idex}
   logic [11:0] act_w;
   assign act_w = {if_gnt, mem_gnt, mc_start, if_drop, stall, IFID_discard_o, IDEX_discard_o};

   // input word: {if_req, mem_req, mc_done, id_load_use, ex_branch_taken}
   typedef struct {
      string       name;
      logic [4:0]  in;
      logic [11:0] exp;
   } vec_t;

   vec_t        tbl[$];
   logic [11:0] exp_q[$];

   pipe_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .if_req         (if_req),
      .mem_req        (mem_req),
      .mc_done        (mc_done),
      .id_load_use    (id_load_use),
      .ex_branch_taken(ex_branch_taken),
      .if_gnt         (if_gnt),
      .mem_gnt        (mem_gnt),
      .mc_start       (mc_start),
      .if_drop        (if_drop),
      .stall          (stall),
      .IFID_discard_o (IFID_discard_o),
      .IDEX_discard_o (IDEX_discard_o)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] o(bit ig, bit mg, bit ms, bit dr, logic [5:0] st, bit fd, bit xd);
      return {ig, mg, ms, dr, st, fd, xd};
   endfunction

   function automatic vec_t mk(string n, logic [4:0] in, logic [11:0] e);
      vec_t v;
      v.name = n;
      v.in   = in;
      v.exp  = e;
      return v;
   endfunction

   task automatic drive(logic [4:0] in);
      {if_req, mem_req, mc_done, id_load_use, ex_branch_taken} = in;
   endtask

   task automatic compare(string name);
      logic [11:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %b", name, act_w);
      end else begin
         e = exp_q.pop_front();
         if (act_w !== e) begin
            n_fail++;
            $display("FAIL %s: got ig/mg/ms/drop/stall/fd/xd=%b required %b", name, act_w, e);
         end
      end
   endtask

   // One clocked cycle: drive after the rising edge, compare on the falling edge.
   task automatic apply(string name, logic [4:0] in, logic [11:0] e);
      @(posedge clk);
      #1;
      drive(in);
      exp_q.push_back(e);
      @(negedge clk);
      compare(name);
   endtask

   localparam logic [11:0] Z = 12'd0;

   initial begin
      // lone fetch, done 3 cycles after grant
      tbl.push_back(mk("lone_req",   5'b10000, o(0,0,0,0,6'h03,0,0)));
      tbl.push_back(mk("lone_gnt",   5'b10000, o(1,0,1,0,6'h03,0,0)));
      tbl.push_back(mk("lone_w1",    5'b10000, o(1,0,0,0,6'h03,0,0)));
      tbl.push_back(mk("lone_w2",    5'b10000, o(1,0,0,0,6'h03,0,0)));
      tbl.push_back(mk("lone_done",  5'b10100, o(1,0,0,0,6'h00,0,0)));
      tbl.push_back(mk("lone_idle",  5'b00000, Z));
      // contention: MEM first, one IDLE cycle, then IF
      tbl.push_back(mk("cont_req",   5'b11000, o(0,0,0,0,6'h1f,0,0)));
      tbl.push_back(mk("cont_mgnt",  5'b11000, o(0,1,1,0,6'h1f,0,0)));
      tbl.push_back(mk("cont_mdone", 5'b11100, o(0,1,0,0,6'h03,0,0)));
      tbl.push_back(mk("cont_idle",  5'b10000, o(0,0,0,0,6'h03,0,0)));
      tbl.push_back(mk("cont_ignt",  5'b10000, o(1,0,1,0,6'h03,0,0)));
      tbl.push_back(mk("cont_idone", 5'b10100, o(1,0,0,0,6'h00,0,0)));
      tbl.push_back(mk("cont_end",   5'b00000, Z));
      // load-use
      tbl.push_back(mk("lu",         5'b00010, o(0,0,0,0,6'h07,0,1)));
      tbl.push_back(mk("lu_end",     5'b00000, Z));
      // branch in 2nd cycle of fetch, done 2 cycles later
      tbl.push_back(mk("bf_req",     5'b10000, o(0,0,0,0,6'h03,0,0)));
      tbl.push_back(mk("bf_gnt",     5'b10000, o(1,0,1,0,6'h03,0,0)));
      tbl.push_back(mk("bf_br",      5'b10001, o(1,0,0,0,6'h03,1,1)));
      tbl.push_back(mk("bf_wait",    5'b10000, o(1,0,0,0,6'h03,0,0)));
      tbl.push_back(mk("bf_done",    5'b10100, o(1,0,0,1,6'h00,0,0)));
      tbl.push_back(mk("bf_end",     5'b00000, Z));
      // next fetch must not be dropped (pending cleared)
      tbl.push_back(mk("nf_req",     5'b10000, o(0,0,0,0,6'h03,0,0)));
      tbl.push_back(mk("nf_gnt",     5'b10000, o(1,0,1,0,6'h03,0,0)));
      tbl.push_back(mk("nf_done",    5'b10100, o(1,0,0,0,6'h00,0,0)));
      tbl.push_back(mk("nf_end",     5'b00000, Z));
      // branch (and load-use) under MEM stall is ignored until done
      tbl.push_back(mk("bm_req",     5'b01000, o(0,0,0,0,6'h1f,0,0)));
      tbl.push_back(mk("bm_br1",     5'b01001, o(0,1,1,0,6'h1f,0,0)));
      tbl.push_back(mk("bm_br2lu",   5'b01011, o(0,1,0,0,6'h1f,0,0)));
      tbl.push_back(mk("bm_done",    5'b01101, o(0,1,0,0,6'h00,1,1)));
      tbl.push_back(mk("bm_end",     5'b00000, Z));
      // branch overrides load-use for discards, stall still applies
      tbl.push_back(mk("br_lu",      5'b00011, o(0,0,0,0,6'h07,1,1)));
      tbl.push_back(mk("br_lu_end",  5'b00000, Z));
      // branch in the completion cycle drops without setting pending
      tbl.push_back(mk("bd_req",     5'b10000, o(0,0,0,0,6'h03,0,0)));
      tbl.push_back(mk("bd_gnt",     5'b10000, o(1,0,1,0,6'h03,0,0)));
      tbl.push_back(mk("bd_donebr",  5'b10101, o(1,0,0,1,6'h00,1,1)));
      tbl.push_back(mk("bd_end",     5'b00000, Z));
      tbl.push_back(mk("bd2_req",    5'b10000, o(0,0,0,0,6'h03,0,0)));
      tbl.push_back(mk("bd2_gnt",    5'b10000, o(1,0,1,0,6'h03,0,0)));
      tbl.push_back(mk("bd2_done",   5'b10100, o(1,0,0,0,6'h00,0,0)));
      tbl.push_back(mk("bd2_end",    5'b00000, Z));

      // reset state
      #2;
      exp_q.push_back(Z);
      compare("reset_outputs");
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      exp_q.push_back(Z);
      compare("post_reset_idle");

      foreach (tbl[i]) apply(tbl[i].name, tbl[i].in, tbl[i].exp);

      // async reset mid MEM_BUSY: outputs clear with no clock edge
      apply("ar_req", 5'b01000, o(0,0,0,0,6'h1f,0,0));
      apply("ar_gnt", 5'b01000, o(0,1,1,0,6'h1f,0,0));
      #2;
      rst = 1'b0;
      #1;
      exp_q.push_back(o(0,0,0,0,6'h1f,0,0));
      compare("ar_async_clear");
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      exp_q.push_back(o(0,0,0,0,6'h1f,0,0));
      compare("ar_released_idle");
      apply("ar_regnt", 5'b01000, o(0,1,1,0,6'h1f,0,0));
      apply("ar_done",  5'b01100, o(0,1,0,0,6'h00,0,0));
      apply("ar_end",   5'b00000, Z);

      // reset with a branch pending: the pending flag is lost
      apply("rp_req", 5'b10000, o(0,0,0,0,6'h03,0,0));
      apply("rp_gnt", 5'b10000, o(1,0,1,0,6'h03,0,0));
      apply("rp_br",  5'b10001, o(1,0,0,0,6'h03,1,1));
      #2;
      drive(5'b10000);
      rst = 1'b0;
      #1;
      exp_q.push_back(o(0,0,0,0,6'h03,0,0));
      compare("rp_async_clear");
      @(posedge clk); #1;
      rst = 1'b1;
      apply("rp_regnt", 5'b10000, o(1,0,1,0,6'h03,0,0));
      apply("rp_done",  5'b10100, o(1,0,0,0,6'h00,0,0));
      apply("rp_end",   5'b00000, Z);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
